// File: rtl/xillybus_seekable_mem.sv
// Seekable word memory behind a Xillybus-style read/write stream pair.
// A single pointer addresses the memory. Each accepted access advances it,
// and a seek loads it directly. With WRAP=0, running past the last word
// parks the pointer in an "end" state that reports EOF/empty/full.
module xillybus_seekable_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int WRAP   = 1
) (
    input  logic              bus_clk,
    input  logic              bus_rst_n,
    input  logic              user_r_rden,
    output logic              user_r_empty,
    output logic [DATA_W-1:0] user_r_data,
    output logic              user_r_eof,
    input  logic              user_r_open,
    input  logic              user_w_wren,
    output logic              user_w_full,
    input  logic [DATA_W-1:0] user_w_data,
    input  logic              user_w_open,
    input  logic [ADDR_W-1:0] user_addr,
    input  logic              user_addr_update
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              end_q, end_d;

    logic              atEnd;
    logic              doWrite;
    logic              doRead;
    logic              accepted;
    logic              streamsClosed;
    logic [ADDR_W-1:0] wordAddr;

    // Decode which accesses are accepted this cycle and where they land
    always_comb begin
        atEnd         = ptr_q[ADDR_W];
        wordAddr      = ptr_q[ADDR_W-1:0];
        doWrite       = user_w_wren && !atEnd;
        doRead        = user_r_rden && !atEnd;
        accepted      = doWrite || doRead;
        streamsClosed = !user_r_open && !user_w_open;
    end

    // Next pointer: a seek wins, then a close rewinds to 0, then one step per accepted cycle
    always_comb begin
        ptr_d = ptr_q;
        if (user_addr_update) begin
            ptr_d = {1'b0, user_addr};
        end else if (streamsClosed) begin
            ptr_d = '0;
        end else if (accepted) begin
            if (WRAP != 0) begin
                ptr_d = {1'b0, wordAddr + {{(ADDR_W-1){1'b0}}, 1'b1}};
            end else begin
                ptr_d = ptr_q + {{ADDR_W{1'b0}}, 1'b1};
            end
        end
        end_d = ptr_d[ADDR_W];
    end

    // Read data updates only on an accepted read; the write lands on the same edge, so
    // the word returned is the one that was there before the write
    always_comb begin
        rdata_d = rdata_q;
        if (doRead) begin
            rdata_d = mem_q[wordAddr];
        end
    end

    // Pointer, read register and end-state flag, cleared asynchronously
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            ptr_q   <= '0;
            rdata_q <= '0;
            end_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            rdata_q <= rdata_d;
            end_q   <= end_d;
        end
    end

    // Memory array write port; the array carries no reset so it maps onto block RAM
    always_ff @(posedge bus_clk) begin
        if (doWrite) begin
            mem_q[wordAddr] <= user_w_data;
        end
    end

    assign user_r_data  = rdata_q;
    assign user_r_empty = end_q;
    assign user_r_eof   = end_q;
    assign user_w_full  = end_q;

endmodule

// File: tb/tb_xillybus_seekable_mem.sv
// Bench for xillybus_seekable_mem. The same stimulus drives a wrapping
// instance and a stopping (WRAP=0) instance, and a high-level model of
// each instance predicts the response.
module tb_xillybus_seekable_mem;

    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk;
    logic          rst_n;
    logic          rden;
    logic          wren;
    logic [DW-1:0] wdata;
    logic          rOpen;
    logic          wOpen;
    logic [AW-1:0] addr;
    logic          addrUpd;

    logic [DW-1:0] rdataW, rdataE;
    logic          emptyW, emptyE, eofW, eofE, fullW, fullE;

    int vectors;
    int miscompares;

    // Model state, index 0 = wrapping instance, index 1 = stopping instance
    int            ptrM  [2];
    logic [DW-1:0] memM  [2][DEPTH];
    logic [DW-1:0] rdM   [2];

    xillybus_seekable_mem #(.DATA_W(DW), .ADDR_W(AW), .WRAP(1)) dutW (
        .bus_clk(clk), .bus_rst_n(rst_n),
        .user_r_rden(rden), .user_r_empty(emptyW), .user_r_data(rdataW),
        .user_r_eof(eofW), .user_r_open(rOpen),
        .user_w_wren(wren), .user_w_full(fullW), .user_w_data(wdata),
        .user_w_open(wOpen), .user_addr(addr), .user_addr_update(addrUpd)
    );

    xillybus_seekable_mem #(.DATA_W(DW), .ADDR_W(AW), .WRAP(0)) dutE (
        .bus_clk(clk), .bus_rst_n(rst_n),
        .user_r_rden(rden), .user_r_empty(emptyE), .user_r_data(rdataE),
        .user_r_eof(eofE), .user_r_open(rOpen),
        .user_w_wren(wren), .user_w_full(fullE), .user_w_data(wdata),
        .user_w_open(wOpen), .user_addr(addr), .user_addr_update(addrUpd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string name);
        logic expEndE;
        expEndE = (ptrM[1] == DEPTH);
        checkOutput({name, " W rdata"}, 32'(rdataW), 32'(rdM[0]));
        checkOutput({name, " W ptr"},   32'(dutW.ptr_q), 32'(ptrM[0]));
        checkOutput({name, " W flags"}, {29'd0, emptyW, eofW, fullW}, 32'd0);
        checkOutput({name, " E rdata"}, 32'(rdataE), 32'(rdM[1]));
        checkOutput({name, " E ptr"},   32'(dutE.ptr_q), 32'(ptrM[1]));
        checkOutput({name, " E flags"}, {29'd0, emptyE, eofE, fullE},
                    {29'd0, expEndE, expEndE, expEndE});
    endtask

    // One clock of stimulus; the model advances from the rules for each instance
    task automatic applyStimulus(input string name, input bit wr, input bit rd,
                                 input logic [DW-1:0] wd, input bit upd,
                                 input logic [AW-1:0] ad, input bit ro = 1'b1,
                                 input bit wo = 1'b1);
        wren    = wr;
        rden    = rd;
        wdata   = wd;
        addrUpd = upd;
        addr    = ad;
        rOpen   = ro;
        wOpen   = wo;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            bit ended;
            ended = (ptrM[k] == DEPTH);
            if (!ended && rd) rdM[k] = memM[k][ptrM[k]];
            if (!ended && wr) memM[k][ptrM[k]] = wd;
            if (upd)                     ptrM[k] = int'(ad);
            else if (!ro && !wo)         ptrM[k] = 0;
            else if (!ended && (wr || rd))
                ptrM[k] = (k == 0) ? (ptrM[k] + 1) % DEPTH : ptrM[k] + 1;
        end
        #1;
        checkAll(name);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n   = 1'b0;
        rden    = 1'b0;
        wren    = 1'b0;
        wdata   = '0;
        addrUpd = 1'b0;
        addr    = '0;
        rOpen   = 1'b1;
        wOpen   = 1'b1;
        for (int k = 0; k < 2; k++) begin
            ptrM[k] = 0;
            rdM[k]  = '0;
        end

        // Reset state
        #2;
        checkAll("reset");
        #1 rst_n = 1'b1;

        // Fill the whole memory so every later read has a defined model value
        applyStimulus("seek0", 0, 0, 8'h00, 1, 5'd0);
        for (int i = 0; i < DEPTH; i++)
            applyStimulus("fill", 1, 0, 8'($urandom), 0, 5'd0);

        // Sequential write then read-back
        applyStimulus("seq seek", 0, 0, 8'h00, 1, 5'd0);
        applyStimulus("seq wr", 1, 0, 8'h11, 0, 5'd0);
        applyStimulus("seq wr", 1, 0, 8'h22, 0, 5'd0);
        applyStimulus("seq wr", 1, 0, 8'h33, 0, 5'd0);
        applyStimulus("seq seek", 0, 0, 8'h00, 1, 5'd0);
        applyStimulus("seq rd", 0, 1, 8'h00, 0, 5'd0);
        checkOutput("seq rd0 const", 32'(rdataW), 32'h11);
        applyStimulus("seq rd", 0, 1, 8'h00, 0, 5'd0);
        checkOutput("seq rd1 const", 32'(rdataE), 32'h22);
        applyStimulus("seq rd", 0, 1, 8'h00, 0, 5'd0);
        checkOutput("seq rd2 const", 32'(rdataW), 32'h33);

        // Wrap at the top of memory (stopping instance enters end state)
        applyStimulus("wrap seek", 0, 0, 8'h00, 1, 5'd31);
        applyStimulus("wrap wr", 1, 0, 8'hAA, 0, 5'd0);
        applyStimulus("wrap wr", 1, 0, 8'hBB, 0, 5'd0);
        checkOutput("wrap ptr const", 32'(dutW.ptr_q), 32'd1);
        applyStimulus("wrap rd", 0, 1, 8'h00, 0, 5'd0);

        // End state: writes and reads ignored while parked
        applyStimulus("end seek", 0, 0, 8'h00, 1, 5'd30);
        applyStimulus("end wr", 1, 0, 8'h01, 0, 5'd0);
        applyStimulus("end wr", 1, 0, 8'h02, 0, 5'd0);
        checkOutput("end full const", 32'(fullE), 32'd1);
        applyStimulus("end wr3", 1, 0, 8'h03, 0, 5'd0);
        applyStimulus("end rd", 0, 1, 8'h00, 0, 5'd0);
        applyStimulus("end wr+rd", 1, 1, 8'h44, 0, 5'd0);

        // Seek out of the end state, then read the target word
        applyStimulus("unpark seek", 0, 0, 8'h00, 1, 5'd4);
        applyStimulus("unpark rd", 0, 1, 8'h00, 0, 5'd0);

        // Seek with a same-cycle access at the old pointer
        applyStimulus("seekacc", 1, 1, 8'h77, 1, 5'd12);

        // Simultaneous read and write returns the pre-write word
        applyStimulus("rbw seek", 0, 0, 8'h00, 1, 5'd7);
        applyStimulus("rbw wr", 1, 0, 8'h5A, 0, 5'd0);
        applyStimulus("rbw seek", 0, 0, 8'h00, 1, 5'd7);
        applyStimulus("rbw wr+rd", 1, 1, 8'hC3, 0, 5'd0);
        checkOutput("rbw rdata const", 32'(rdataW), 32'h5A);
        applyStimulus("rbw seek", 0, 0, 8'h00, 1, 5'd7);
        applyStimulus("rbw rd", 0, 1, 8'h00, 0, 5'd0);

        // Closing both streams rewinds the pointer but keeps memory
        applyStimulus("close", 0, 0, 8'h00, 0, 5'd0, 0, 0);
        applyStimulus("close rd", 0, 1, 8'h00, 0, 5'd0);

        // Asynchronous reset in the middle of operation
        applyStimulus("rst seek", 0, 0, 8'h00, 1, 5'd2);
        applyStimulus("rst rd", 0, 1, 8'h00, 0, 5'd0);
        for (int i = 0; i < 6; i++)
            applyStimulus("rst wr", 1, 0, 8'($urandom), 0, 5'd0);
        checkOutput("rst pre ptr", 32'(dutW.ptr_q), 32'd9);
        wren = 1'b0;
        rden = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            ptrM[k] = 0;
            rdM[k]  = '0;
        end
        checkAll("in reset");
        #1 rst_n = 1'b1;
        applyStimulus("post rst rd", 0, 1, 8'h00, 0, 5'd0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            bit closeBoth;
            closeBoth = ($urandom_range(0, 19) == 0);
            applyStimulus("rand", 1'($urandom), 1'($urandom), 8'($urandom),
                          ($urandom_range(0, 7) == 0), 5'($urandom),
                          !closeBoth, !closeBoth);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
